// File: rtl/compute_op_responder.sv
// rtl/compute_op_responder.sv - compute-engine handshake responder with per-op latency table
module compute_op_responder #(
  parameter int OP_W        = 32,
  parameter int NUM_OPS     = 8,
  parameter int LAT_W       = 8,
  parameter int DEFAULT_LAT = 3,
  parameter int CNT_W       = 16,
  localparam int AW         = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             compute_start,
  input  logic             compute_start_ap_vld,
  input  logic [OP_W-1:0]  compute_op,
  output logic             compute_ready,
  output logic             compute_done,
  output logic             eng_start,
  output logic [OP_W-1:0]  eng_op,
  input  logic             lat_cfg_we,
  input  logic [AW-1:0]    lat_cfg_addr,
  input  logic [LAT_W-1:0] lat_cfg_data,
  input  logic             err_clr,
  output logic             err_start_busy,
  output logic             err_bad_op,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             eng_start_q, eng_start_d;
  logic [OP_W-1:0]  eng_op_q, eng_op_d;
  logic             err_busy_q, err_busy_d;
  logic             err_bad_q, err_bad_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [LAT_W-1:0] lat_tab_q [NUM_OPS];
  logic [LAT_W-1:0] lat_tab_d [NUM_OPS];

  logic             start_vld;
  logic             accept;
  logic             op_legal;
  logic [AW-1:0]    op_idx;
  logic [LAT_W-1:0] tab_lat;
  logic [LAT_W-1:0] accept_lat;

  // Accept decode and latency lookup; the table is read from the registered copy so a
  // same-edge write never affects the op being accepted.
  always_comb begin
    start_vld  = compute_start & compute_start_ap_vld;
    accept     = (state_q == S_IDLE) & start_vld & ready_q;
    op_legal   = (compute_op < OP_W'(NUM_OPS));
    op_idx     = compute_op[AW-1:0];
    tab_lat    = lat_tab_q[op_idx];
    accept_lat = LAT_W'(DEFAULT_LAT);
    if (op_legal) begin
      accept_lat = (tab_lat == '0) ? LAT_W'(1) : tab_lat;
    end
  end

  // Next-state and registered-output logic for the IDLE -> EXEC -> DONE handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    eng_start_d = 1'b0;
    eng_op_d    = eng_op_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d     = S_EXEC;
          cnt_d       = accept_lat;
          ready_d     = 1'b0;
          eng_start_d = 1'b1;
          eng_op_d    = compute_op;
        end
      end
      S_EXEC: begin
        if (cnt_q <= LAT_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        ready_d    = 1'b1;
        op_count_d = op_count_q + CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Sticky error flags; a new error event on the same edge as err_clr keeps the flag set.
  always_comb begin
    err_busy_d = (err_busy_q & ~err_clr) | (start_vld & ~ready_q);
    err_bad_d  = (err_bad_q & ~err_clr) | (accept & ~op_legal);
  end

  // Latency table update; addresses beyond the table never match an entry.
  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      lat_tab_d[i] = lat_tab_q[i];
      if (lat_cfg_we && (32'(lat_cfg_addr) == 32'(i))) begin
        lat_tab_d[i] = lat_cfg_data;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_op_q    <= '0;
      err_busy_q  <= 1'b0;
      err_bad_q   <= 1'b0;
      op_count_q  <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        lat_tab_q[i] <= LAT_W'(DEFAULT_LAT);
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      eng_start_q <= eng_start_d;
      eng_op_q    <= eng_op_d;
      err_busy_q  <= err_busy_d;
      err_bad_q   <= err_bad_d;
      op_count_q  <= op_count_d;
      for (int i = 0; i < NUM_OPS; i++) begin
        lat_tab_q[i] <= lat_tab_d[i];
      end
    end
  end

  assign compute_ready  = ready_q;
  assign compute_done   = done_q;
  assign eng_start      = eng_start_q;
  assign eng_op         = eng_op_q;
  assign err_start_busy = err_busy_q;
  assign err_bad_op     = err_bad_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_compute_op_responder.sv
// tb/tb_compute_op_responder.sv - self-checking bench for compute_op_responder
module tb_compute_op_responder;

  localparam int OP_W        = 32;
  localparam int NUM_OPS     = 8;
  localparam int LAT_W       = 8;
  localparam int DEFAULT_LAT = 3;
  localparam int CNT_W       = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             compute_start;
  logic             compute_start_ap_vld;
  logic [OP_W-1:0]  compute_op;
  logic             compute_ready;
  logic             compute_done;
  logic             eng_start;
  logic [OP_W-1:0]  eng_op;
  logic             lat_cfg_we;
  logic [2:0]       lat_cfg_addr;
  logic [LAT_W-1:0] lat_cfg_data;
  logic             err_clr;
  logic             err_start_busy;
  logic             err_bad_op;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int n_el   = 0;
  int model_tab [NUM_OPS];
  int model_cnt;
  bit model_bad;

  compute_op_responder #(
    .OP_W(OP_W), .NUM_OPS(NUM_OPS), .LAT_W(LAT_W),
    .DEFAULT_LAT(DEFAULT_LAT), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .compute_start(compute_start),
    .compute_start_ap_vld(compute_start_ap_vld),
    .compute_op(compute_op),
    .compute_ready(compute_ready),
    .compute_done(compute_done),
    .eng_start(eng_start),
    .eng_op(eng_op),
    .lat_cfg_we(lat_cfg_we),
    .lat_cfg_addr(lat_cfg_addr),
    .lat_cfg_data(lat_cfg_data),
    .err_clr(err_clr),
    .err_start_busy(err_start_busy),
    .err_bad_op(err_bad_op),
    .op_count(op_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int op);
    if (op < 0 || op >= NUM_OPS) return DEFAULT_LAT;
    return (model_tab[op] == 0) ? 1 : model_tab[op];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_OPS; i++) model_tab[i] = DEFAULT_LAT;
    model_cnt = 0;
    model_bad = 1'b0;
  endtask

  task automatic tick();
    @(negedge ap_clk);
    n_el++;
  endtask

  task automatic cfg_write(input int addr, input int data);
    lat_cfg_we   = 1'b1;
    lat_cfg_addr = 3'(addr);
    lat_cfg_data = LAT_W'(data);
    tick();
    lat_cfg_we   = 1'b0;
    model_tab[addr] = data;
  endtask

  task automatic start_op(input int op);
    compute_start        = 1'b1;
    compute_start_ap_vld = 1'b1;
    compute_op           = OP_W'(op);
    tick();
    compute_start        = 1'b0;
    compute_start_ap_vld = 1'b0;
    n_el = 0;
    if (op >= NUM_OPS) model_bad = 1'b1;
    check("acc_eng_start", eng_start, 1);
    check("acc_eng_op", eng_op, op);
    check("acc_ready", compute_ready, 0);
    check("acc_bad_op", err_bad_op, model_bad);
  endtask

  task automatic wait_done(input string tag, input int exp_l);
    while (!compute_done && n_el < 600) tick();
    check({tag, "_latency"}, n_el, exp_l);
    check({tag, "_ready_at_done"}, compute_ready, 0);
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    tick();
    check({tag, "_done_one_cycle"}, compute_done, 0);
    check({tag, "_ready_back"}, compute_ready, 1);
    check({tag, "_op_count"}, op_count, model_cnt);
  endtask

  initial begin
    int seen;
    int lat;
    int a;
    int d;
    int op;

    ap_rst_n             = 1'b0;
    compute_start        = 1'b0;
    compute_start_ap_vld = 1'b0;
    compute_op           = '0;
    lat_cfg_we           = 1'b0;
    lat_cfg_addr         = '0;
    lat_cfg_data         = '0;
    err_clr              = 1'b0;
    model_reset();
    repeat (2) tick();
    ap_rst_n = 1'b1;

    check("rst_ready", compute_ready, 1);
    check("rst_done", compute_done, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_op", eng_op, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err_busy", err_start_busy, 0);
    check("rst_err_bad", err_bad_op, 0);

    // default latency op
    start_op(2);
    tick();
    check("t1_eng_start_pulse", eng_start, 0);
    wait_done("t1", 3);

    // table writes, zero treated as one
    cfg_write(5, 0);
    cfg_write(1, 10);
    start_op(5);
    wait_done("t2_op5", 1);
    start_op(1);
    wait_done("t2_op1", 10);

    // busy start ignored and flagged; clear; clear colliding with new error
    start_op(1);
    tick();
    compute_start = 1'b1; compute_start_ap_vld = 1'b1; compute_op = 4;
    tick();
    compute_start = 1'b0; compute_start_ap_vld = 1'b0;
    check("t3_busy_set", err_start_busy, 1);
    check("t3_eng_op_held", eng_op, 1);
    check("t3_eng_start_quiet", eng_start, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_busy_clr", err_start_busy, 0);
    err_clr = 1'b1; compute_start = 1'b1; compute_start_ap_vld = 1'b1;
    tick();
    err_clr = 1'b0; compute_start = 1'b0; compute_start_ap_vld = 1'b0;
    check("t3_set_wins", err_start_busy, 1);
    wait_done("t3", exp_lat(1));

    // illegal op and unqualified start
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    model_bad = 1'b0;
    check("t4_flags_clear", {err_start_busy, err_bad_op}, 0);
    start_op(9);
    wait_done("t4_bad", DEFAULT_LAT);
    compute_start = 1'b1; compute_start_ap_vld = 1'b0; compute_op = 2;
    tick();
    check("t4_novld_eng_start", eng_start, 0);
    check("t4_novld_ready", compute_ready, 1);
    tick();
    compute_start = 1'b0;
    check("t4_novld_busy", err_start_busy, 0);
    check("t4_novld_count", op_count, model_cnt);

    // reset mid-op
    start_op(1);
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    model_reset();
    check("t5_ready", compute_ready, 1);
    check("t5_done", compute_done, 0);
    check("t5_op_count", op_count, 0);
    check("t5_eng_op", eng_op, 0);
    check("t5_bad", err_bad_op, 0);
    seen = 0;
    repeat (15) begin
      tick();
      if (compute_done) seen = 1;
    end
    check("t5_no_done", seen, 0);
    start_op(1);
    wait_done("t5_tab_restored", DEFAULT_LAT);

    // counter wrap and same-edge write/accept
    force dut.op_count_q = 16'hFFFF;
    tick();
    release dut.op_count_q;
    model_cnt = 65535;
    tick();
    check("t6_preload", op_count, 16'hFFFF);
    lat_cfg_we = 1'b1; lat_cfg_addr = 0; lat_cfg_data = 7;
    lat = exp_lat(0);
    start_op(0);
    lat_cfg_we = 1'b0;
    model_tab[0] = 7;
    wait_done("t6_wrap_old_lat", lat);
    start_op(0);
    wait_done("t6_new_lat", 7);

    // randomized ops against the table model
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    model_bad = 1'b0;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, 7), $urandom_range(0, 12));
      op = $urandom_range(0, 11);
      lat = exp_lat(op);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 7);
        d = $urandom_range(0, 12);
        lat_cfg_we = 1'b1; lat_cfg_addr = 3'(a); lat_cfg_data = LAT_W'(d);
        start_op(op);
        lat_cfg_we = 1'b0;
        model_tab[a] = d;
      end else begin
        start_op(op);
      end
      wait_done("rnd", lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
